// File: rtl/positencode.sv
// rtl/positencode.sv - packs sign/scale/fraction into an N-bit posit, round-to-nearest-even, 3-stage pipeline
module positencode #(
   parameter int N  = 32,
   parameter int es = 2,
   parameter int SW = 8,
   parameter int FW = 30
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          sign,
   input  logic [SW-1:0] scale,
   input  logic [FW-1:0] frac,
   input  logic          zero_in,
   input  logic          inf_in,
   output logic [N-1:0]  result,
   output logic          inf,
   output logic          zero,
   output logic          done
);
   localparam int WW   = N + FW + 2;
   localparam int PW   = WW - 2 - es - FW;
   localparam int MAXS = (N - 2) * (2 ** es);

   // stage 1: registered operand, regime run k, exponent bits, saturation flags
   logic                 v1_d, v1_q, sign1_d, sign1_q, inf1_d, inf1_q, zero1_d, zero1_q;
   logic                 sat_hi1_d, sat_hi1_q, sat_lo1_d, sat_lo1_q;
   logic signed [SW-1:0] k1_d, k1_q;
   logic [es-1:0]        e1_d, e1_q;
   logic [FW-1:0]        frac1_d, frac1_q;

   // stage 2: truncated body with guard/sticky
   logic                 v2_d, v2_q, sign2_d, sign2_q, inf2_d, inf2_q, zero2_d, zero2_q;
   logic                 sat_hi2_d, sat_hi2_q, sat_lo2_d, sat_lo2_q;
   logic                 guard2_d, guard2_q, sticky2_d, sticky2_q;
   logic [N-2:0]         body2_d, body2_q;

   // stage 3: output registers
   logic [N-1:0]         result_d, result_q;
   logic                 inf_d, inf_q, zero_d, zero_q, done_d, done_q;

   logic [WW-1:0]        w_pos, w_neg, w;
   logic [SW-1:0]        nk;
   logic                 rnd;
   logic [N-1:0]         sum, mag;
   logic [N-2:0]         body3;

   always_comb begin
      v1_d      = start;
      sign1_d   = sign;
      k1_d      = $signed(scale) >>> es;
      e1_d      = scale[es-1:0];
      frac1_d   = frac;
      sat_hi1_d = $signed(scale) > MAXS;
      sat_lo1_d = $signed(scale) < -MAXS;
      inf1_d    = inf_in;
      zero1_d   = zero_in & ~inf_in;
   end

   // Arithmetic shift of a leading 1 builds k+1 ones then 0; for k<0 shift 01 right by -k-1.
   always_comb begin
      nk        = ~k1_q;
      w_pos     = $signed({2'b10, e1_q, frac1_q, {PW{1'b0}}}) >>> k1_q;
      w_neg     = {2'b01, e1_q, frac1_q, {PW{1'b0}}} >> nk;
      w         = k1_q[SW-1] ? w_neg : w_pos;
      body2_d   = w[WW-1 -: N-1];
      guard2_d  = w[WW-N];
      sticky2_d = |w[WW-N-1:0];
      v2_d      = v1_q;
      sign2_d   = sign1_q;
      sat_hi2_d = sat_hi1_q;
      sat_lo2_d = sat_lo1_q;
      inf2_d    = inf1_q;
      zero2_d   = zero1_q;
   end

   always_comb begin
      rnd   = guard2_q & (body2_q[0] | sticky2_q);
      sum   = {1'b0, body2_q} + {{(N-1){1'b0}}, rnd};
      body3 = sum[N-2:0];
      if (sum[N-1])
         body3 = {(N-1){1'b1}};
      else if (sum == '0)
         body3 = {{(N-2){1'b0}}, 1'b1};
      if (sat_hi2_q)
         body3 = {(N-1){1'b1}};
      else if (sat_lo2_q)
         body3 = {{(N-2){1'b0}}, 1'b1};
      mag      = {1'b0, body3};
      result_d = result_q;
      inf_d    = inf_q;
      zero_d   = zero_q;
      done_d   = v2_q;
      if (v2_q) begin
         inf_d  = inf2_q;
         zero_d = zero2_q;
         if (inf2_q)
            result_d = {1'b1, {(N-1){1'b0}}};
         else if (zero2_q)
            result_d = '0;
         else
            result_d = sign2_q ? -mag : mag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         inf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         done_q   <= done_d;
         result_q <= result_d;
         inf_q    <= inf_d;
         zero_q   <= zero_d;
      end
      sign1_q   <= sign1_d;
      k1_q      <= k1_d;
      e1_q      <= e1_d;
      frac1_q   <= frac1_d;
      sat_hi1_q <= sat_hi1_d;
      sat_lo1_q <= sat_lo1_d;
      inf1_q    <= inf1_d;
      zero1_q   <= zero1_d;
      sign2_q   <= sign2_d;
      body2_q   <= body2_d;
      guard2_q  <= guard2_d;
      sticky2_q <= sticky2_d;
      sat_hi2_q <= sat_hi2_d;
      sat_lo2_q <= sat_lo2_d;
      inf2_q    <= inf2_d;
      zero2_q   <= zero2_d;
   end

   assign result = result_q;
   assign inf    = inf_q;
   assign zero   = zero_q;
   assign done   = done_q;
endmodule

// File: tb/tb_positencode.sv
// tb/tb_positencode.sv - scoreboard bench for positencode against a bit-string posit model
module tb_positencode;
   logic        clk = 1'b0;
   logic        reset, start, sign, zero_in, inf_in;
   logic [7:0]  scale;
   logic [29:0] frac;
   logic [31:0] result;
   logic        inf, zero, done;

   typedef struct {
      logic [33:0] exp;
      int          at;
   } exp_t;

   exp_t sbq[$];
   exp_t mx;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   positencode dut (
      .clk(clk), .reset(reset), .start(start), .sign(sign), .scale(scale), .frac(frac),
      .zero_in(zero_in), .inf_in(inf_in), .result(result), .inf(inf), .zero(zero), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: write out regime/exponent/fraction as a bit list, cut at 31 bits, round.
   function automatic logic [33:0] model(bit s, int sc, logic [29:0] f, bit z, bit i);
      int          k, e;
      bit          bits[$];
      longint      body;
      bit          guard, sticky;
      logic [31:0] r;
      if (i) return {2'b10, 32'h8000_0000};
      if (z) return {2'b01, 32'h0000_0000};
      k = (sc >= 0) ? sc / 4 : -((-sc + 3) / 4);
      e = sc - 4 * k;
      if (k >= 0) begin
         repeat (k + 1) bits.push_back(1'b1);
         bits.push_back(1'b0);
      end else begin
         repeat (-k) bits.push_back(1'b0);
         bits.push_back(1'b1);
      end
      bits.push_back(e[1]);
      bits.push_back(e[0]);
      for (int n = 29; n >= 0; n--) bits.push_back(f[n]);
      body = 0;
      for (int n = 0; n < 31; n++) body = body * 2 + ((n < bits.size()) ? longint'(bits[n]) : 0);
      guard  = (bits.size() > 31) ? bits[31] : 1'b0;
      sticky = 1'b0;
      for (int n = 32; n < bits.size(); n++) sticky |= bits[n];
      if (guard && ((body % 2) == 1 || sticky)) body++;
      if (body > 64'h7FFF_FFFF) body = 64'h7FFF_FFFF;
      if (body < 1) body = 1;
      if (sc > 120) body = 64'h7FFF_FFFF;
      if (sc < -120) body = 1;
      r = body[31:0];
      if (s) r = -r;
      return {2'b00, r};
   endfunction

   task automatic issue(bit s, int sc, logic [29:0] f, bit z, bit i);
      @(negedge clk);
      start = 1'b1; sign = s; scale = sc[7:0]; frac = f; zero_in = z; inf_in = i;
      sbq.push_back('{model(s, sc, f, z, i), cyc + 3});
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         start = 1'b0; sign = 1'($urandom); scale = 8'($urandom); frac = 30'($urandom);
         zero_in = 1'($urandom); inf_in = 1'($urandom);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done got result=%h inf=%0b zero=%0b want no done", result, inf, zero);
         end else begin
            mx = sbq.pop_front();
            if ({inf, zero, result} !== mx.exp || cyc != mx.at) begin
               bad++;
               $display("FAIL done_check got inf=%0b zero=%0b result=%h cyc=%0d want inf=%0b zero=%0b result=%h cyc=%0d",
                        inf, zero, result, cyc, mx.exp[33], mx.exp[32], mx.exp[31:0], mx.at);
            end
         end
      end
   end

   initial begin
      int sc;
      reset = 1'b1; start = 1'b0; sign = 1'b0; scale = '0; frac = '0; zero_in = 1'b0; inf_in = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({result, inf, zero, done} !== 35'd0) begin
         bad++;
         $display("FAIL reset_state got result=%h inf=%0b zero=%0b done=%0b want all 0", result, inf, zero, done);
      end
      reset = 1'b0;
      idle(2);

      issue(0, 0, 30'h0, 0, 0);
      idle(4);
      issue(0, 1, 30'h0, 0, 0);
      issue(0, -1, 30'h0, 0, 0);
      issue(1, 0, 30'h0, 0, 0);
      issue(0, 0, {27'h7FF_FFFF, 3'b100}, 0, 0);
      issue(0, 0, {27'h0, 3'b100}, 0, 0);
      issue(0, 120, 30'h0, 0, 0);
      issue(0, 127, 30'h3FFF_FFFF, 0, 0);
      issue(0, -120, 30'h0, 0, 0);
      issue(0, -128, 30'h0, 0, 0);
      issue(1, -117, 30'h0, 0, 0);
      issue(0, 123, 30'h3FFF_FFFF, 0, 0);
      issue(0, 5, 30'h1234, 0, 1);
      issue(1, 5, 30'h1234, 1, 0);
      issue(1, 5, 30'h1234, 1, 1);
      idle(5);

      issue(0, 9, 30'h155, 0, 0);
      issue(0, 17, 30'h2AA, 0, 0);
      @(negedge clk);
      start = 1'b0; reset = 1'b1;
      sbq.delete();
      @(negedge clk);
      total++;
      if ({result, inf, zero, done} !== 35'd0) begin
         bad++;
         $display("FAIL reset_flush got result=%h inf=%0b zero=%0b done=%0b want all 0", result, inf, zero, done);
      end
      reset = 1'b0;
      idle(6);

      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(3) == 0) idle(1);
         else begin
            sc = ($urandom_range(3) == 0) ? int'($signed(8'($urandom))) : $urandom_range(60) - 30;
            issue(1'($urandom), sc, 30'($urandom), $urandom_range(15) == 0, $urandom_range(15) == 0);
         end
      end
      idle(1);

      for (int t = 0; t < 20 && sbq.size() != 0; t++) @(negedge clk);
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout got pending=%0d want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
